// File: rtl/pll_fir_sched.sv
// Scheduler for the ADPLL low-pass cascade: three decimating FIR stages share one
// MAC datapath; this block grants jobs, issues tap sequences and raises df_update.
`timescale 1ns/1ps
module pll_fir_sched #(
    parameter int NTAPS   = 21,
    parameter int TAP_W   = 5,
    parameter int DEC     = 10,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sample_valid,
    input  logic             ovr_clr,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             mac_last,
    output logic [TAP_W-1:0] tap_idx,
    output logic [1:0]       mac_stage,
    output logic [2:0]       stage_done,
    output logic             df_update,
    output logic             busy,
    output logic [2:0]       ovr
);

    localparam int CW = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(NTAPS - 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(MAC_LAT - 1);
    localparam logic [CW-1:0]    CNT_LAST   = CW'(DEC - 1);

    function automatic logic [2:0] stage_onehot(input logic [1:0] stage);
        case (stage)
            2'd1:    stage_onehot = 3'b001;
            2'd2:    stage_onehot = 3'b010;
            2'd3:    stage_onehot = 3'b100;
            default: stage_onehot = 3'b000;
        endcase
    endfunction

    logic [1:0]       state_r, state_s;
    logic [DW-1:0]    drain_r, drain_s;
    logic [TAP_W-1:0] tap_s;
    logic [1:0]       stage_s;
    logic [2:0]       pending_r, pending_s;
    logic [CW-1:0]    cnt1_r, cnt2_r;
    logic [2:0]       req_s, grant_s, ovr_s, done_s;

    // Request sources and fixed-priority grant (stage 1 first), only from IDLE with en
    always_comb begin
        req_s[0] = sample_valid & en;
        req_s[1] = stage_done[0] & (cnt1_r == CNT_LAST);
        req_s[2] = stage_done[1] & (cnt2_r == CNT_LAST);
        grant_s  = 3'b000;
        if ((state_r == S_IDLE) && en) begin
            if (pending_r[0]) begin
                grant_s = 3'b001;
            end else if (pending_r[1]) begin
                grant_s = 3'b010;
            end else if (pending_r[2]) begin
                grant_s = 3'b100;
            end else begin
                grant_s = 3'b000;
            end
        end else begin
            grant_s = 3'b000;
        end
        // A request coinciding with its own grant re-arms the bit instead of overrunning
        pending_s = (pending_r & ~grant_s) | req_s;
        ovr_s     = ((ovr_clr == 1'b1) ? 3'b000 : ovr) | (req_s & pending_r & ~grant_s);
    end

    // Job sequencing: IDLE -> RUN (NTAPS taps) -> DRAIN (MAC_LAT cycles) -> IDLE
    always_comb begin
        state_s = state_r;
        drain_s = drain_r;
        tap_s   = {TAP_W{1'b0}};
        stage_s = mac_stage;
        case (state_r)
            S_IDLE: begin
                drain_s = {DW{1'b0}};
                if (grant_s != 3'b000) begin
                    state_s = S_RUN;
                    stage_s = grant_s[0] ? 2'd1 : (grant_s[1] ? 2'd2 : 2'd3);
                end else begin
                    stage_s = 2'd0;
                end
            end
            S_RUN: begin
                if (tap_idx == TAP_LAST) begin
                    state_s = S_DRAIN;
                    drain_s = {DW{1'b0}};
                end else begin
                    tap_s = tap_idx + TAP_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_r == DRAIN_LAST) begin
                    state_s = S_IDLE;
                    stage_s = 2'd0;
                end else begin
                    drain_s = drain_r + DW'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                stage_s = 2'd0;
            end
        endcase
        if ((state_s == S_DRAIN) && (drain_s == DRAIN_LAST)) begin
            done_s = stage_onehot(stage_s);
        end else begin
            done_s = 3'b000;
        end
    end

    // State, request bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            drain_r    <= {DW{1'b0}};
            pending_r  <= 3'b000;
            cnt1_r     <= {CW{1'b0}};
            cnt2_r     <= {CW{1'b0}};
            mac_en     <= 1'b0;
            mac_clr    <= 1'b0;
            mac_last   <= 1'b0;
            tap_idx    <= {TAP_W{1'b0}};
            mac_stage  <= 2'd0;
            stage_done <= 3'b000;
            df_update  <= 1'b0;
            busy       <= 1'b0;
            ovr        <= 3'b000;
        end else begin
            state_r    <= state_s;
            drain_r    <= drain_s;
            pending_r  <= pending_s;
            if (stage_done[0]) begin
                cnt1_r <= (cnt1_r == CNT_LAST) ? {CW{1'b0}} : cnt1_r + CW'(1);
            end else begin
                cnt1_r <= cnt1_r;
            end
            if (stage_done[1]) begin
                cnt2_r <= (cnt2_r == CNT_LAST) ? {CW{1'b0}} : cnt2_r + CW'(1);
            end else begin
                cnt2_r <= cnt2_r;
            end
            mac_en     <= (state_s == S_RUN);
            mac_clr    <= (state_s == S_RUN) && (tap_s == {TAP_W{1'b0}});
            mac_last   <= (state_s == S_RUN) && (tap_s == TAP_LAST);
            tap_idx    <= tap_s;
            mac_stage  <= stage_s;
            stage_done <= done_s;
            df_update  <= done_s[2];
            busy       <= (state_s != S_IDLE);
            ovr        <= ovr_s;
        end
    end

endmodule

// File: tb/tb_pll_fir_sched.sv
// Directed bench for pll_fir_sched: expected stage_done pulses are queued with their
// cycle numbers when stimulus is issued, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_pll_fir_sched;

    logic       clk = 1'b0;
    logic       rst_n, en, sample_valid, ovr_clr;
    logic       mac_en, mac_clr, mac_last, df_update, busy;
    logic [4:0] tap_idx;
    logic [1:0] mac_stage;
    logic [2:0] stage_done, ovr;

    typedef struct {
        int         cyc;
        logic [2:0] done;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n2 = 0;
    int   n3 = 0;

    pll_fir_sched #(.NTAPS(21), .TAP_W(5), .DEC(10), .MAC_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_valid(sample_valid), .ovr_clr(ovr_clr),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last), .tap_idx(tap_idx),
        .mac_stage(mac_stage), .stage_done(stage_done), .df_update(df_update),
        .busy(busy), .ovr(ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int c);
        while (cyc < c) tick();
    endtask

    task automatic sample_at(input int c);
        go(c);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic push(input int c, input logic [2:0] d);
        exp_t e;
        e.cyc  = c;
        e.done = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        en = 1'b0;
        sample_valid = 1'b0;
        ovr_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: every stage_done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] stg;
        if (stage_done !== 3'b000) begin
            if (stage_done[1] === 1'b1) n2++;
            if (stage_done[2] === 1'b1) n3++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got %b expected none (cycle %0d)", stage_done, cyc);
            end else begin
                e = sb.pop_front();
                stg = e.done[0] ? 2'd1 : (e.done[1] ? 2'd2 : 2'd3);
                check("done_cycle", cyc, e.cyc);
                check("done_bits", {29'd0, stage_done}, {29'd0, e.done});
                check("done_stage", {30'd0, mac_stage}, {30'd0, stg});
                check("df_update", {31'd0, df_update}, {31'd0, e.done[2]});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b, t;
        rst_n = 1'b0;
        en = 1'b0;
        sample_valid = 1'b0;
        ovr_clr = 1'b0;
        @(negedge clk);
        check("rst_outputs", {mac_en, mac_clr, mac_last, tap_idx, mac_stage, stage_done, df_update, busy, ovr},
              32'd0);

        // Single sample: latency chain
        do_reset();
        t = cyc + 2;
        sample_at(t);
        push(t + 24, 3'b001);
        go(t + 2);  @(negedge clk);
        check("tap0_en", {31'd0, mac_en}, 32'd1);
        check("tap0_clr", {31'd0, mac_clr}, 32'd1);
        check("tap0_idx", {27'd0, tap_idx}, 32'd0);
        check("tap0_stage", {30'd0, mac_stage}, 32'd1);
        go(t + 3);  @(negedge clk);
        check("tap1_clr", {31'd0, mac_clr}, 32'd0);
        check("tap1_idx", {27'd0, tap_idx}, 32'd1);
        go(t + 22); @(negedge clk);
        check("tap20_last", {31'd0, mac_last}, 32'd1);
        check("tap20_idx", {27'd0, tap_idx}, 32'd20);
        go(t + 23); @(negedge clk);
        check("drain_en", {31'd0, mac_en}, 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd1);
        go(t + 25); @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_stage", {30'd0, mac_stage}, 32'd0);
        check("idle_ovr", {29'd0, ovr}, 32'd0);

        // 100 samples spaced 100 cycles: decimation into stages 2 and 3
        do_reset();
        n2 = 0;
        n3 = 0;
        b = cyc + 2;
        for (int k = 0; k < 100; k++) begin
            t = b + 100 * k;
            push(t + 24, 3'b001);
            if (k % 10 == 9) push(t + 48, 3'b010);
            if (k == 99) push(t + 72, 3'b100);
            sample_at(t);
            if (k == 9) begin
                go(t + 26); @(negedge clk);
                check("s2_grant_stage", {30'd0, mac_stage}, 32'd2);
            end
            if (k == 99) begin
                go(t + 50); @(negedge clk);
                check("s3_grant_stage", {30'd0, mac_stage}, 32'd3);
            end
        end
        go(b + 100 * 100 + 10); @(negedge clk);
        check("count_stage2", n2, 32'd10);
        check("count_stage3", n3, 32'd1);
        check("dec_ovr", {29'd0, ovr}, 32'd0);

        // Samples every 20 cycles: the one at +120 finds pending[0] still set
        do_reset();
        b = cyc + 2;
        push(b + 24, 3'b001);  push(b + 48, 3'b001);  push(b + 72, 3'b001);
        push(b + 96, 3'b001);  push(b + 120, 3'b001); push(b + 144, 3'b001);
        push(b + 168, 3'b001);
        for (int k = 0; k < 6; k++) sample_at(b + 20 * k);
        go(b + 120);
        sample_valid = 1'b1;
        @(negedge clk);
        check("ovr_before", {29'd0, ovr}, 32'd0);
        tick();
        sample_valid = 1'b0;
        @(negedge clk);
        check("ovr_rise", {29'd0, ovr}, 32'd1);
        sample_at(b + 140);
        go(b + 141); @(negedge clk);
        check("ovr_sticky", {29'd0, ovr}, 32'd1);
        go(b + 176);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        @(negedge clk);
        check("ovr_cleared", {29'd0, ovr}, 32'd0);

        // Stage 1 and stage 2 pending together, plus a sample coincident with a stage-1 grant
        do_reset();
        b = cyc + 2;
        for (int k = 0; k < 10; k++) begin
            push(b + 30 * k + 24, 3'b001);
            sample_at(b + 30 * k);
        end
        t = b + 270;
        push(t + 48, 3'b001);
        push(t + 72, 3'b001);
        push(t + 96, 3'b010);
        sample_at(t + 23);
        go(t + 25);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        @(negedge clk);
        check("prio_first", {30'd0, mac_stage}, 32'd1);
        go(t + 50); @(negedge clk);
        check("prio_rearm", {30'd0, mac_stage}, 32'd1);
        go(t + 74); @(negedge clk);
        check("prio_second", {30'd0, mac_stage}, 32'd2);
        go(t + 100); @(negedge clk);
        check("prio_ovr", {29'd0, ovr}, 32'd0);

        // Asynchronous reset at tap 10 aborts the job with no stage_done
        do_reset();
        b = cyc + 2;
        sample_at(b);
        go(b + 12); @(negedge clk);
        check("abort_tap10", {27'd0, tap_idx}, 32'd10);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_async", {mac_en, mac_clr, mac_last, tap_idx, mac_stage, stage_done, df_update, busy, ovr},
              32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        go(b + 60);

        // en low mid-RUN: job completes, no new grant until en returns
        do_reset();
        b = cyc + 2;
        push(b + 24, 3'b001);
        sample_at(b);
        sample_at(b + 3);
        go(b + 5);
        en = 1'b0;
        sample_at(b + 10);
        go(b + 30); @(negedge clk);
        check("en_hold_busy", {31'd0, busy}, 32'd0);
        check("en_hold_stage", {30'd0, mac_stage}, 32'd0);
        go(b + 40);
        en = 1'b1;
        push(b + 63, 3'b001);
        go(b + 41); @(negedge clk);
        check("en_resume_stage", {30'd0, mac_stage}, 32'd1);
        check("en_resume_clr", {31'd0, mac_clr}, 32'd1);
        go(b + 100); @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
